// File: rtl/pc_branch_unit.sv
// Program-counter stage: forms branch/jump targets, holds the PC behind a
// valid/ready fetch handshake and parks redirects that arrive while fetch is
// stalled. Optional saturating redirect counter: define PC_BRANCH_UNIT_PERF_CNT_EN.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             ready_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic [31:0]      branch_base_i,
    input  logic [31:0]      offset_sl2_i,
    input  logic [25:0]      jump_addr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             valid_o,
    output logic             redirect_pend_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PEND  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;

    logic        fire;
    logic        redirect;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    assign branch_target = branch_base_i + offset_sl2_i;
    assign jump_target   = {branch_base_i[31:28], jump_addr_i, 2'b00};
    assign target        = jump_i ? jump_target : branch_target;
    assign redirect      = jump_i | branch_i;

    assign valid_o         = (state_q != ST_BOOT);
    assign fire            = valid_o & ready_i & ~stall_i;
    assign redirect_pend_o = (state_q == ST_PEND);
    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pend_d  = target;
                    state_d = ST_PEND;
                end
            end
            ST_FETCH: begin
                if (fire) begin
                    pc_d = redirect ? target : pc_plus4_o;
                end else if (redirect) begin
                    pend_d  = target;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // A redirect arriving with the fire is newer than the parked one.
                if (fire) begin
                    pc_d    = redirect ? target : pend_q;
                    pend_d  = 32'd0;
                    state_d = ST_FETCH;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PC_BRANCH_UNIT_PERF_CNT_EN
    logic             applied;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The PC loads a target on a redirecting fire in FETCH or any fire in PEND.
    assign applied = fire & (redirect | (state_q == ST_PEND));

    always_comb begin
        cnt_d = cnt_q;
        if (applied && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt_o = cnt_q;
`else
    assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: vector table plus a hand-written
// long-stall sequence, with expected outputs routed through a scoreboard queue.
module tb_pc_branch_unit;

    localparam int CNT_W = 16;
`ifdef PC_BRANCH_UNIT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic             ready_i;
    logic             branch_i;
    logic             jump_i;
    logic [31:0]      branch_base_i;
    logic [31:0]      offset_sl2_i;
    logic [25:0]      jump_addr_i;
    logic [31:0]      pc_o;
    logic [31:0]      pc_plus4_o;
    logic             valid_o;
    logic             redirect_pend_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    pc_branch_unit #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .ready_i        (ready_i),
        .branch_i       (branch_i),
        .jump_i         (jump_i),
        .branch_base_i  (branch_base_i),
        .offset_sl2_i   (offset_sl2_i),
        .jump_addr_i    (jump_addr_i),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .valid_o        (valid_o),
        .redirect_pend_o(redirect_pend_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst, stall, ready, br, jp;
        logic [31:0] base, off;
        logic [25:0] ja;
        logic [31:0] pc;
        logic        valid, pend;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid, pend;
        logic [15:0] cnt;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs[NV];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mk(logic rst, logic stall, logic ready, logic br, logic jp,
                                logic [31:0] base, logic [31:0] off, logic [25:0] ja,
                                logic [31:0] pc, logic valid, logic pend, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.ready = ready; v.br = br; v.jp = jp;
        v.base = base; v.off = off; v.ja = ja;
        v.pc = pc; v.valid = valid; v.pend = pend; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(int idx, vec_t v);
        exp_t e;
        @(negedge clk_i);
        rst_i = v.rst; stall_i = v.stall; ready_i = v.ready;
        branch_i = v.br; jump_i = v.jp;
        branch_base_i = v.base; offset_sl2_i = v.off; jump_addr_i = v.ja;
        e.pc = v.pc; e.valid = v.valid; e.pend = v.pend;
        e.cnt = PERF ? v.cnt : 16'd0;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_pc", idx), pc_o, e.pc);
            chk($sformatf("v%0d_pc_plus4", idx), pc_plus4_o, e.pc + 32'd4);
            chk($sformatf("v%0d_valid", idx), {31'd0, valid_o}, {31'd0, e.valid});
            chk($sformatf("v%0d_pend", idx), {31'd0, redirect_pend_o}, {31'd0, e.pend});
            chk($sformatf("v%0d_cnt", idx), {16'd0, redirect_cnt_o}, {16'd0, e.cnt});
        end
        $display("vec %0d: pc=%h valid=%0b pend=%0b cnt=%0d", idx, pc_o, valid_o,
                 redirect_pend_o, redirect_cnt_o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; ready_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
        branch_base_i = '0; offset_sl2_i = '0; jump_addr_i = '0;

        //            rst  stl  rdy  br   jp   base          off           ja            pc            vld  pnd  cnt
        vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b0,1'b0,16'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b1,1'b0,16'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h4,        1'b1,1'b0,16'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h8,        1'b1,1'b0,16'd0);
        vecs[4]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'hC,        1'b1,1'b0,16'd0);
        vecs[5]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h10,       1'b1,1'b0,16'd0);
        vecs[6]  = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h14,       32'hFFFF_FFF0,26'h0,        32'h4,        1'b1,1'b0,16'd1);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h4000_0020,32'h0,        26'h100,      32'h4,        1'b1,1'b1,16'd1);
        vecs[8]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h4000_0400,1'b1,1'b0,16'd2);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h4000_0020,32'h0,        26'h100,      32'h4000_0400,1'b1,1'b1,16'd2);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,32'h100,      32'h40,       26'h0,        32'h4000_0400,1'b1,1'b1,16'd2);
        vecs[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h140,      1'b1,1'b0,16'd3);
        vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h8,        32'h20,       26'h10,       32'h40,       1'b1,1'b0,16'd4);
        vecs[13] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        32'hFFFF_FFFC,26'h0,        32'hFFFF_FFFC,1'b1,1'b0,16'd5);
        vecs[14] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b1,1'b0,16'd5);
        vecs[15] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b1,1'b0,16'd5);
        vecs[16] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,32'h20,       32'h8,        26'h0,        32'h0,        1'b1,1'b1,16'd5);
        vecs[17] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,        32'h0,        26'h40,       32'h100,      1'b1,1'b0,16'd6);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,32'h200,      32'h4,        26'h0,        32'h100,      1'b1,1'b1,16'd6);
        vecs[19] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,32'h200,      32'h4,        26'h0,        32'h0,        1'b0,1'b0,16'd0);
        vecs[20] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b1,1'b0,16'd0);
        vecs[21] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h4,        1'b1,1'b0,16'd0);
        vecs[22] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h0,        1'b0,1'b0,16'd0);
        vecs[23] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h1000,     32'h10,       26'h0,        32'h0,        1'b1,1'b1,16'd0);
        vecs[24] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h1010,     1'b1,1'b0,16'd1);
        vecs[25] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        26'h0,        32'h1014,     1'b1,1'b0,16'd1);

        for (int i = 0; i < NV; i++) begin
            apply(i, vecs[i]);
        end

        // Fetch back-pressure for several cycles holds the PC, then it resumes.
        for (int i = 0; i < 4; i++) begin
            apply(NV + i, mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,26'h0,32'h1014,1'b1,1'b0,16'd1));
        end
        apply(NV + 4, mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,26'h0,32'h1018,1'b1,1'b0,16'd1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
